// File: rtl/aes_pkg.sv
// Shared AES key-expansion types, sizes and the round-constant helper.
package aes_pkg;

  localparam int unsigned KeySize   = 128;
  localparam int unsigned NumRounds = 10;
  localparam int unsigned RoundKeys = NumRounds + 1;

  typedef logic [3:0]         round_idx_t;
  typedef logic [KeySize-1:0] round_key_t;

  // Highest valid store index and the rc value of the final expansion round
  localparam round_idx_t LastIdx = round_idx_t'(NumRounds);
  localparam round_idx_t LastRc  = round_idx_t'(NumRounds - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} kx_state_t;

  // Round constant for expansion round rc (0-based); rc 10..15 never issued
  function automatic logic [7:0] rcon(input round_idx_t rc);
    logic [7:0] r;
    case (rc)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_schedule.sv
// One combinational AES-128 key-expansion round: key_o = next round key of key_i.
// Word w0 sits in [31:0]; byte 0 of each word is in its MSBs.
module key_schedule
  import aes_pkg::*;
(
  input  round_idx_t rc_i,
  input  round_key_t key_i,
  output round_key_t key_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] rot;
  logic [31:0] tmp;
  logic [31:0] n0, n1, n2, n3;

  // RotWord/SubWord/Rcon on w3, then the xor chain across the four words
  always_comb begin
    rot = {key_i[119:96], key_i[127:120]};
    tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon(rc_i), 24'h000000};
    n0  = key_i[31:0]   ^ tmp;
    n1  = key_i[63:32]  ^ n0;
    n2  = key_i[95:64]  ^ n1;
    n3  = key_i[127:96] ^ n2;
    key_o = {n3, n2, n1, n0};
  end

endmodule

// File: rtl/round_key_store.sv
// 11 x 128 round-key register file: one write port, one registered read port,
// synchronous clear that also wipes the read register.
module round_key_store
  import aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       we_i,
  input  round_idx_t waddr_i,
  input  round_key_t wdata_i,
  input  logic       re_i,
  input  round_idx_t raddr_i,
  output round_key_t rdata_o,
  output logic       rvalid_o
);

  round_key_t mem_q [RoundKeys];
  round_key_t rdata_q;
  logic       rvalid_q;

  // Key array: clear wins over write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RoundKeys); i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < int'(RoundKeys); i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i <= LastIdx)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: samples the pre-write array, so same-cycle read returns old data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (clr_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) rdata_q <= (raddr_i <= LastIdx) ? mem_q[raddr_i] : '0;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/key_expand_ctrl.sv
// Iterative AES-128 key-expansion controller: accepts a key, runs key_schedule
// for 10 rounds (one per cycle) and keeps all 11 round keys for the cipher core.
// Optional zeroize port and clear behaviour: define KEY_EXPAND_ZEROIZE_EN.
module key_expand_ctrl
  import aes_pkg::kx_state_t, aes_pkg::round_idx_t, aes_pkg::round_key_t;
  import aes_pkg::IDLE, aes_pkg::EXPAND, aes_pkg::DONE, aes_pkg::LastRc;
#(
  parameter int unsigned KeySize   = 128,
  parameter int unsigned NumRounds = 10
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef KEY_EXPAND_ZEROIZE_EN
  input  logic       zeroize,
`endif
  input  logic       key_valid,
  output logic       key_ready,
  input  round_key_t key_in,
  input  logic       rk_rd_en,
  input  round_idx_t rk_idx,
  output round_key_t rk_out,
  output logic       rk_out_valid,
  output logic       keys_valid,
  output logic       busy
);

  if (KeySize != 128) begin : g_bad_key_size
    $error("key_expand_ctrl: only KeySize = 128 is supported");
  end
  if (NumRounds != aes_pkg::NumRounds) begin : g_bad_num_rounds
    $error("key_expand_ctrl: only NumRounds = 10 is supported");
  end

  kx_state_t  state_q, state_d;
  round_idx_t rc_q, rc_d;
  round_key_t cur_q, cur_d;
  round_key_t key_next;
  logic       zero_req;
  logic       accept;
  logic       st_we;
  round_idx_t st_waddr;
  round_key_t st_wdata;

`ifdef KEY_EXPAND_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign accept = key_valid & key_ready & ~zero_req;

  // State register; cur_q mirrors rk[rc] so key_schedule needs no store read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cur_q   <= cur_d;
    end
  end

  // Next-state: zeroize first, then acceptance from IDLE/DONE, then round stepping
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cur_d   = cur_q;
    if (zero_req) begin
      state_d = IDLE;
      rc_d    = '0;
      cur_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d = EXPAND;
            rc_d    = '0;
            cur_d   = key_in;
          end
        end
        EXPAND: begin
          cur_d = key_next;
          if (rc_q == LastRc) begin
            state_d = DONE;
            rc_d    = '0;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and store write port decoded from the current state
  always_comb begin
    key_ready  = (state_q != EXPAND);
    busy       = (state_q == EXPAND);
    keys_valid = (state_q == DONE);
    st_we      = 1'b0;
    st_waddr   = '0;
    st_wdata   = key_next;
    if (accept) begin
      st_we    = 1'b1;
      st_wdata = key_in;
    end else if ((state_q == EXPAND) && !zero_req) begin
      st_we    = 1'b1;
      st_waddr = rc_q + 4'd1;
    end
  end

  key_schedule u_key_schedule (
    .rc_i  (rc_q),
    .key_i (cur_q),
    .key_o (key_next)
  );

  round_key_store u_round_key_store (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (zero_req),
    .we_i     (st_we),
    .waddr_i  (st_waddr),
    .wdata_i  (st_wdata),
    .re_i     (rk_rd_en),
    .raddr_i  (rk_idx),
    .rdata_o  (rk_out),
    .rvalid_o (rk_out_valid)
  );

endmodule
